// File: rtl/ahb_lite_ram_responder_if.sv
// AHB-Lite manager-to-subordinate bundle as seen at the arbiter output.
// The manager drives address, control and write data; the subordinate drives the response.
interface ahb_lite_ram_responder_if;
   logic        auto_in_hmastlock;
   logic        auto_in_hready;
   logic [1:0]  auto_in_htrans;
   logic [2:0]  auto_in_hsize;
   logic [2:0]  auto_in_hburst;
   logic        auto_in_hwrite;
   logic [3:0]  auto_in_hprot;
   logic [30:0] auto_in_haddr;
   logic [31:0] auto_in_hwdata;
   logic        auto_in_hreadyout;
   logic        auto_in_hresp;
   logic [31:0] auto_in_hrdata;

   modport master (
      output auto_in_hmastlock, auto_in_hready, auto_in_htrans, auto_in_hsize,
             auto_in_hburst, auto_in_hwrite, auto_in_hprot, auto_in_haddr, auto_in_hwdata,
      input  auto_in_hreadyout, auto_in_hresp, auto_in_hrdata
   );

   modport slave (
      input  auto_in_hmastlock, auto_in_hready, auto_in_htrans, auto_in_hsize,
             auto_in_hburst, auto_in_hwrite, auto_in_hprot, auto_in_haddr, auto_in_hwdata,
      output auto_in_hreadyout, auto_in_hresp, auto_in_hrdata
   );
endinterface

// File: rtl/ahb_lite_ram_responder.sv
// AHB-Lite subordinate backed by a flop word RAM: programmable wait states,
// byte-laned writes, combinational reads and the two-cycle ERROR response.
module ahb_lite_ram_responder #(
   parameter logic [30:0] BASE_ADDR   = 31'h0000_0000,
   parameter int          DEPTH_WORDS = 256,
   parameter int          WAIT_STATES = 1
) (
   input logic                         clock,
   input logic                         reset_n,
   ahb_lite_ram_responder_if.slave     bus
);
   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

   state_t        r_state, w_next;
   logic [2:0]    r_cnt;
   logic          r_vld, r_legal, r_write;
   logic [2:0]    r_size;
   logic [AW+1:0] r_addr;
   logic [31:0]   r_mem [DEPTH_WORDS];

   logic          w_ready, w_resp, w_accept, w_legal, w_misal, w_inrange, w_commit, w_rd_en;
   logic [3:0]    w_be;
   logic [AW-1:0] w_idx;
   logic          w_unused;

   assign w_unused = ^{bus.auto_in_hmastlock, bus.auto_in_hburst, bus.auto_in_hprot};

   // Decode legality of the address phase currently on the bus
   assign w_misal   = (bus.auto_in_hsize == 3'd1 && bus.auto_in_haddr[0]) ||
                      (bus.auto_in_hsize == 3'd2 && bus.auto_in_haddr[1:0] != 2'b00);
   assign w_inrange = bus.auto_in_haddr[30:AW+2] == BASE_ADDR[30:AW+2];
   assign w_legal   = (bus.auto_in_hsize <= 3'd2) && !w_misal && w_inrange;
   assign w_accept  = w_ready && bus.auto_in_hready && bus.auto_in_htrans[1];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_ready = 1'b1;
      w_resp  = 1'b0;
      case (r_state)
         S_IDLE, S_ERR2: begin
            w_resp = (r_state == S_ERR2);
            if (w_accept)
               w_next = !w_legal ? S_ERR1 : (WAIT_STATES > 0) ? S_WAIT : S_IDLE;
            else
               w_next = S_IDLE;
         end
         S_WAIT: begin
            w_ready = 1'b0;
            if (r_cnt == 3'd1) w_next = S_IDLE;
         end
         S_ERR1: begin
            w_ready = 1'b0;
            w_resp  = 1'b1;
            w_next  = S_ERR2;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Pending data-phase transfer; retires on any cycle with hreadyout high
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_vld   <= 1'b0;
         r_legal <= 1'b0;
         r_write <= 1'b0;
         r_size  <= 3'd0;
         r_addr  <= '0;
         r_cnt   <= 3'd0;
      end else begin
         if (w_ready) r_vld <= w_accept;
         if (w_accept) begin
            r_legal <= w_legal;
            r_write <= bus.auto_in_hwrite;
            r_size  <= bus.auto_in_hsize;
            r_addr  <= bus.auto_in_haddr[AW+1:0];
            r_cnt   <= w_legal ? 3'(WAIT_STATES) : 3'd0;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 3'd1;
         end
      end
   end

   assign w_idx    = r_addr[AW+1:2];
   assign w_commit = r_vld && r_legal && r_write && w_ready;
   assign w_rd_en  = r_vld && r_legal && !r_write && w_ready;

   always_comb begin
      w_be = 4'b0000;
      case (r_size)
         3'd0:    w_be[r_addr[1:0]] = 1'b1;
         3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   // RAM contents deliberately survive reset
   always_ff @(posedge clock) begin
      if (w_commit) begin
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= bus.auto_in_hwdata[8*b +: 8];
      end
   end

   assign bus.auto_in_hreadyout = w_ready;
   assign bus.auto_in_hresp     = w_resp;
   assign bus.auto_in_hrdata    = w_rd_en ? r_mem[w_idx] : 32'h0;
endmodule

// File: tb/tb_ahb_lite_ram_responder.sv
// Scoreboarded bench: three responders (WAIT_STATES 1, 0, 5) driven by directed transfers.
module tb_ahb_lite_ram_responder;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int          waits;
      logic        r1;
      logic        resp;
      logic [31:0] rdata;
   } exp_t;

   logic [1:0]  tr [3];
   logic [2:0]  sz [3];
   logic        wr [3];
   logic [30:0] ad [3];
   logic [31:0] wd [3];
   logic        rstn [3];
   logic        rdy [3];
   logic        rsp [3];
   logic [31:0] rd [3];

   logic        rdy_s [3] = '{1'b0, 1'b0, 1'b0};
   bit          act [3]   = '{1'b0, 1'b0, 1'b0};
   bit          first [3];
   logic        r1 [3];
   int          wcnt [3];

   exp_t q0[$], q1[$], q2[$];
   exp_t me;
   int   n_tot = 0, n_pass = 0;

   ahb_lite_ram_responder_if bif [3] ();

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 5;
      assign bif[g].auto_in_hmastlock = 1'b0;
      assign bif[g].auto_in_hready    = bif[g].auto_in_hreadyout;
      assign bif[g].auto_in_htrans    = tr[g];
      assign bif[g].auto_in_hsize     = sz[g];
      assign bif[g].auto_in_hburst    = 3'd0;
      assign bif[g].auto_in_hwrite    = wr[g];
      assign bif[g].auto_in_hprot     = 4'd0;
      assign bif[g].auto_in_haddr     = ad[g];
      assign bif[g].auto_in_hwdata    = wd[g];
      assign rdy[g] = bif[g].auto_in_hreadyout;
      assign rsp[g] = bif[g].auto_in_hresp;
      assign rd[g]  = bif[g].auto_in_hrdata;

      ahb_lite_ram_responder #(.BASE_ADDR(31'h0), .DEPTH_WORDS(256), .WAIT_STATES(WS)) u_dut (
         .clock   (clock),
         .reset_n (rstn[g]),
         .bus     (bif[g])
      );
   end

   task automatic chk(string nm, logic [31:0] got, logic [31:0] req);
      n_tot++;
      if (got === req) n_pass++;
      else $display("FAIL %s: got %h required %h", nm, got, req);
   endtask

   function automatic exp_t mk(int w, logic a, logic b, logic [31:0] d);
      exp_t e;
      e.waits = w; e.r1 = a; e.resp = b; e.rdata = d;
      return e;
   endfunction

   function automatic void push(int d, exp_t e);
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic bit pop(int d, output exp_t e);
      bit ok;
      e = mk(0, 1'b0, 1'b0, 32'h0);
      case (d)
         0:       begin ok = q0.size() > 0; if (ok) e = q0.pop_front(); end
         1:       begin ok = q1.size() > 0; if (ok) e = q1.pop_front(); end
         default: begin ok = q2.size() > 0; if (ok) e = q2.pop_front(); end
      endcase
      return ok;
   endfunction

   // Address-phase acceptance as the bus sees it
   always @(posedge clock) begin
      for (int d = 0; d < 3; d++)
         if (rstn[d] && rdy_s[d] && tr[d][1]) begin
            act[d] = 1'b1; first[d] = 1'b1; wcnt[d] = 0;
         end
   end

   // Data-phase monitor: scores each completed phase against the queue
   always @(negedge clock) begin
      for (int d = 0; d < 3; d++) begin
         if (!rstn[d]) act[d] = 1'b0;
         else if (act[d]) begin
            if (first[d]) begin r1[d] = rsp[d]; first[d] = 1'b0; end
            if (!rdy[d]) wcnt[d]++;
            else begin
               act[d] = 1'b0;
               if (!pop(d, me)) chk($sformatf("d%0d_sb_underflow", d), 32'd1, 32'd0);
               else begin
                  chk($sformatf("d%0d_waits", d), wcnt[d], me.waits);
                  chk($sformatf("d%0d_first_resp", d), {31'd0, r1[d]}, {31'd0, me.r1});
                  chk($sformatf("d%0d_resp", d), {31'd0, rsp[d]}, {31'd0, me.resp});
                  chk($sformatf("d%0d_rdata", d), rd[d], me.rdata);
               end
            end
         end
         rdy_s[d] = rdy[d];
      end
   end

   task automatic step_rdy(int d);
      int n = 0;
      do begin @(posedge clock); n++; end while (!rdy_s[d] && n < 100);
      if (!rdy_s[d]) chk($sformatf("d%0d_ready_timeout", d), 32'd0, 32'd1);
   endtask

   task automatic xfer(int d, bit w, logic [2:0] s, logic [30:0] a, logic [31:0] wdata, exp_t e);
      push(d, e);
      tr[d] = 2'd2; wr[d] = w; sz[d] = s; ad[d] = a;
      step_rdy(d);
      #1 tr[d] = 2'd0; wd[d] = wdata;
      step_rdy(d);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         tr[d] = 2'd0; sz[d] = 3'd2; wr[d] = 1'b0; ad[d] = '0; wd[d] = '0; rstn[d] = 1'b0;
      end
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_hreadyout", {31'd0, rdy[0]}, 32'd1);
      chk("rst_hresp", {31'd0, rsp[0]}, 32'd0);
      chk("rst_hrdata", rd[0], 32'd0);
      @(posedge clock); #1;
      for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
      @(posedge clock); #1;

      // IDLE / BUSY never insert waits
      for (int i = 0; i < 5; i++) begin
         tr[0] = (i % 2) ? 2'd1 : 2'd0;
         @(negedge clock);
         chk($sformatf("idle_busy_ready_%0d", i), {31'd0, rdy[0]}, 32'd1);
         @(posedge clock); #1;
      end
      tr[0] = 2'd0;

      // Word write/read, WAIT_STATES=1
      xfer(0, 1, 3'd2, 31'h10, 32'hDEADBEEF, mk(1, 0, 0, 32'h0));
      xfer(0, 0, 3'd2, 31'h10, 32'h0,        mk(1, 0, 0, 32'hDEADBEEF));
      // Byte lanes
      xfer(0, 1, 3'd2, 31'h20, 32'h11223344, mk(1, 0, 0, 32'h0));
      xfer(0, 1, 3'd0, 31'h22, 32'h00AA0000, mk(1, 0, 0, 32'h0));
      xfer(0, 1, 3'd1, 31'h20, 32'h0000BBCC, mk(1, 0, 0, 32'h0));
      xfer(0, 0, 3'd2, 31'h20, 32'h0,        mk(1, 0, 0, 32'h11AABBCC));
      xfer(0, 1, 3'd2, 31'h00, 32'h01020304, mk(1, 0, 0, 32'h0));
      // Illegal transfers: misaligned halfword, out of range (aliases word 0), size 3
      xfer(0, 1, 3'd1, 31'h21,  32'h55555555, mk(1, 1, 1, 32'h0));
      xfer(0, 1, 3'd2, 31'h400, 32'h66666666, mk(1, 1, 1, 32'h0));
      xfer(0, 1, 3'd3, 31'h20,  32'h77777777, mk(1, 1, 1, 32'h0));
      xfer(0, 0, 3'd2, 31'h20, 32'h0, mk(1, 0, 0, 32'h11AABBCC));
      xfer(0, 0, 3'd2, 31'h00, 32'h0, mk(1, 0, 0, 32'h01020304));
      xfer(0, 0, 3'd2, 31'h404, 32'h0, mk(1, 1, 1, 32'h0));

      // Pipelined stream, WAIT_STATES=0
      push(1, mk(0, 0, 0, 32'h0));
      push(1, mk(0, 0, 0, 32'h0));
      push(1, mk(0, 0, 0, 32'hA5A50001));
      push(1, mk(0, 0, 0, 32'h5A5A0002));
      tr[1] = 2'd2; wr[1] = 1'b1; sz[1] = 3'd2; ad[1] = 31'h0;
      @(posedge clock); #1 tr[1] = 2'd3; ad[1] = 31'h4; wd[1] = 32'hA5A50001;
      @(posedge clock); #1 wr[1] = 1'b0; ad[1] = 31'h0; wd[1] = 32'h5A5A0002;
      @(posedge clock); #1 ad[1] = 31'h4;
      @(posedge clock); #1 tr[1] = 2'd0;
      @(posedge clock); #1;

      // Reset in WAIT, WAIT_STATES=5: aborted write must not land
      xfer(2, 1, 3'd2, 31'h30, 32'hCAFEF00D, mk(5, 0, 0, 32'h0));
      tr[2] = 2'd2; wr[2] = 1'b1; sz[2] = 3'd2; ad[2] = 31'h30;
      step_rdy(2);
      #1 tr[2] = 2'd0; wd[2] = 32'h0BAD0BAD;
      @(posedge clock);
      #2 rstn[2] = 1'b0;
      #1;
      chk("wait_rst_hreadyout", {31'd0, rdy[2]}, 32'd1);
      chk("wait_rst_hresp", {31'd0, rsp[2]}, 32'd0);
      chk("wait_rst_hrdata", rd[2], 32'd0);
      #5 rstn[2] = 1'b1;
      @(posedge clock); #1;
      xfer(2, 0, 3'd2, 31'h30, 32'h0, mk(5, 0, 0, 32'hCAFEF00D));

      repeat (2) @(posedge clock);
      chk("sb_left_d0", q0.size(), 32'd0);
      chk("sb_left_d1", q1.size(), 32'd0);
      chk("sb_left_d2", q2.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
